// File: rtl/input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// input_conditioner_pkg
// Shared types and constants for the board input front end and for the
// service FSMs that consume its pulses.
//   mode_e       : mode_sel encodings (MODE_IDLE .. MODE_ALARM_ON)
//   BTN_*        : push[] bit indices (up, down, left, right, middle)
//   rep_state_e  : per-button auto-repeat FSM states
//   cnt_width    : counter width for a terminal count (never below 1 bit)
//   decode_mode  : priority decode of switches spdt[14:11]
// ---------------------------------------------------------------------------
package input_conditioner_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE      = 3'd0,
        MODE_TIME_SET  = 3'd1,
        MODE_ALARM_SET = 3'd2,
        MODE_STOPWATCH = 3'd3,
        MODE_ALARM_ON  = 3'd4
    } mode_e;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_MID   = 4;

    localparam int NUM_PUSH    = 5;
    localparam int NUM_GAME_SW = 10;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // sel[3] = spdt[14] ... sel[0] = spdt[11]; the highest switch wins.
    function automatic mode_e decode_mode(input logic [3:0] sel);
        if (sel[3]) return MODE_TIME_SET;
        if (sel[2]) return MODE_ALARM_SET;
        if (sel[1]) return MODE_STOPWATCH;
        if (sel[0]) return MODE_ALARM_ON;
        return MODE_IDLE;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
// One raw input: 2-FF synchroniser, stability counter and rising-edge detect.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   pin_i   : raw asynchronous input
//   sync_o  : synchronised (not yet debounced) value
//   level_o : debounced level
//   rise_o  : high for exactly one cycle after level_o goes 0->1
// The level only follows the synchronised value after it has differed from
// the current level for DEBOUNCE_CYCLES consecutive cycles.
// ---------------------------------------------------------------------------
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic sync_o,
    output logic level_o,
    output logic rise_o
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where sync agrees with the stable level restarts the count,
    // so a glitch has to persist for the full window to be accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q       <= 1'b0;
            sync_q       <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            meta_q       <= pin_i;
            sync_q       <= meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign sync_o  = sync_q;
    assign level_o = stable_q;
    assign rise_o  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Front end between raw board pins and the clock core: synchronise and
// debounce every button/switch, produce one-cycle press pulses, decode the
// service-select switches and auto-repeat held up/down buttons.
//   clk_osc    in   1   board oscillator clock
//   rst        in   1   asynchronous active-high reset
//   push       in   5   raw buttons [0]up [1]down [2]left [3]right [4]middle
//   spdt       in   14  raw switches spdt[14:1]
//   push_level out  5   debounced button levels
//   push_pulse out  5   press pulses; [1:0] also carry auto-repeat pulses
//   sw_level   out  10  debounced game switches spdt[10:1]
//   sw_rise    out  10  one-cycle pulse on debounced 0->1 of spdt[10:1]
//   mode_sel   out  3   decoded service mode (mode_e)
//   mode_chg   out  1   one-cycle pulse in the cycle mode_sel changes
// ---------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic        clk_osc,
    input  logic        rst,
    input  logic [4:0]  push,
    input  logic [14:1] spdt,
    output logic [4:0]  push_level,
    output logic [4:0]  push_pulse,
    output logic [9:0]  sw_level,
    output logic [9:0]  sw_rise,
    output logic [2:0]  mode_sel,
    output logic        mode_chg
);

    localparam int            RW         = cnt_width(max_int(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    // Reset asserts immediately but is released on a clock edge, so no flop
    // sees reset removal near its sampling point.
    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk_osc or posedge rst) begin
        if (rst) begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic [4:0]  push_sync, push_lvl, push_rise;
    logic [14:1] spdt_sync, spdt_lvl, spdt_rise;

    for (genvar i = 0; i < NUM_PUSH; i++) begin : g_push
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (clk_osc),
            .rst_i   (rst_sync_q),
            .pin_i   (push[i]),
            .sync_o  (push_sync[i]),
            .level_o (push_lvl[i]),
            .rise_o  (push_rise[i])
        );
    end

    for (genvar j = 1; j <= 14; j++) begin : g_spdt
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (clk_osc),
            .rst_i   (rst_sync_q),
            .pin_i   (spdt[j]),
            .sync_o  (spdt_sync[j]),
            .level_o (spdt_lvl[j]),
            .rise_o  (spdt_rise[j])
        );
    end

    // Mode switches are level-only and switch sync values are not needed.
    logic unused_bits;
    assign unused_bits = ^{spdt_sync, spdt_rise[14:11]};

    mode_e       mode_sel_q, mode_dec;
    logic        mode_chg_q, mode_chg_d;
    logic [4:0]  push_pulse_q, push_pulse_d;
    logic [4:0]  armed_q, armed_d;
    logic [4:0]  press;
    logic [9:0]  sw_rise_q, sw_rise_d;
    logic        both_held;
    logic [1:0]  rep_pulse;
    rep_state_e  rep_state_q [2];
    rep_state_e  rep_state_d [2];
    logic [RW-1:0] rep_cnt_q [2];
    logic [RW-1:0] rep_cnt_d [2];

    always_comb begin
        mode_dec   = decode_mode(spdt_lvl[14:11]);
        mode_chg_d = (mode_dec != mode_sel_q);
        both_held  = push_lvl[BTN_UP] & push_lvl[BTN_DOWN];
        armed_d    = armed_q;
        press      = '0;
        rep_pulse  = '0;

        // armed drops when the mode changes while the button is down or a
        // press is still being debounced; it comes back only once both the
        // synchronised pin and the debounced level are low again.
        for (int b = 0; b < NUM_PUSH; b++) begin
            if (!push_lvl[b] && !push_sync[b]) begin
                armed_d[b] = 1'b1;
            end else if (mode_chg_d) begin
                armed_d[b] = 1'b0;
            end
            press[b] = push_rise[b] & armed_q[b] & ~mode_chg_d;
        end

        for (int b = 0; b < 2; b++) begin
            rep_state_d[b] = rep_state_q[b];
            rep_cnt_d[b]   = rep_cnt_q[b];
            if (mode_chg_d || !push_lvl[b] || both_held) begin
                rep_state_d[b] = REP_IDLE;
                rep_cnt_d[b]   = '0;
            end else begin
                case (rep_state_q[b])
                    REP_IDLE: begin
                        if (press[b]) begin
                            rep_state_d[b] = REP_DELAY;
                            rep_cnt_d[b]   = '0;
                        end
                    end
                    REP_DELAY: begin
                        if (rep_cnt_q[b] == DELAY_LAST) begin
                            rep_state_d[b] = REP_REPEAT;
                            rep_cnt_d[b]   = '0;
                            rep_pulse[b]   = 1'b1;
                        end else if (rep_cnt_q[b] != '1) begin
                            rep_cnt_d[b] = rep_cnt_q[b] + 1'b1;
                        end
                    end
                    REP_REPEAT: begin
                        if (rep_cnt_q[b] == RATE_LAST) begin
                            rep_cnt_d[b] = '0;
                            rep_pulse[b] = 1'b1;
                        end else if (rep_cnt_q[b] != '1) begin
                            rep_cnt_d[b] = rep_cnt_q[b] + 1'b1;
                        end
                    end
                    default: begin
                        rep_state_d[b] = REP_IDLE;
                        rep_cnt_d[b]   = '0;
                    end
                endcase
            end
        end

        push_pulse_d = press | {3'b000, rep_pulse};
        sw_rise_d    = spdt_rise[10:1];
    end

    always_ff @(posedge clk_osc or posedge rst_sync_q) begin
        if (rst_sync_q) begin
            mode_sel_q   <= MODE_IDLE;
            mode_chg_q   <= 1'b0;
            push_pulse_q <= '0;
            armed_q      <= '1;
            sw_rise_q    <= '0;
            for (int b = 0; b < 2; b++) begin
                rep_state_q[b] <= REP_IDLE;
                rep_cnt_q[b]   <= '0;
            end
        end else begin
            mode_sel_q   <= mode_dec;
            mode_chg_q   <= mode_chg_d;
            push_pulse_q <= push_pulse_d;
            armed_q      <= armed_d;
            sw_rise_q    <= sw_rise_d;
            for (int b = 0; b < 2; b++) begin
                rep_state_q[b] <= rep_state_d[b];
                rep_cnt_q[b]   <= rep_cnt_d[b];
            end
        end
    end

    assign push_level = push_lvl;
    assign push_pulse = push_pulse_q;
    assign sw_level   = spdt_lvl[10:1];
    assign sw_rise    = sw_rise_q;
    assign mode_sel   = mode_sel_q;
    assign mode_chg   = mode_chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner
// Drives the input conditioner with short debounce/repeat windows. Each
// stimulus pushes the pulse events it should cause ({cycle, mode, channel})
// onto exp_q; a negedge monitor pops and compares every observed pulse.
// Channels: 0..4 push_pulse, 5..14 sw_rise, 15 mode_chg (with mode_sel).
// ---------------------------------------------------------------------------
module tb_input_conditioner;

    localparam int D       = 4;
    localparam int RD      = 16;
    localparam int RR      = 8;
    localparam int LAT     = 2 + D + 1;   // pin edge to pulse
    localparam int RST_LAT = 2;           // internal reset release delay

    logic        clk_osc = 1'b0;
    logic        rst;
    logic [4:0]  push;
    logic [14:1] spdt;
    logic [4:0]  push_level, push_pulse;
    logic [9:0]  sw_level, sw_rise;
    logic [2:0]  mode_sel;
    logic        mode_chg;

    input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk_osc    (clk_osc),
        .rst        (rst),
        .push       (push),
        .spdt       (spdt),
        .push_level (push_level),
        .push_pulse (push_pulse),
        .sw_level   (sw_level),
        .sw_rise    (sw_rise),
        .mode_sel   (mode_sel),
        .mode_chg   (mode_chg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk_osc = ~clk_osc;

    int cyc = 0;
    always @(posedge clk_osc) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [27:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [27:0] mk_ev(input int c, input int ch, input logic [2:0] m);
        logic [31:0] cv;
        logic [31:0] chv;
        cv  = c;
        chv = ch;
        return {cv[19:0], m, chv[4:0]};
    endfunction

    task automatic expect_ev(input int c, input int ch, input logic [2:0] m);
        exp_q.push_back(mk_ev(c, ch, m));
    endtask

    task automatic observe(input logic [27:0] ev);
        if (exp_q.size() == 0) check("unexpected_pulse", {36'd0, ev}, 64'd0);
        else check("pulse_event", {36'd0, ev}, {36'd0, exp_q.pop_front()});
    endtask

    always @(negedge clk_osc) begin
        for (int ch = 0; ch < 5; ch++)
            if (push_pulse[ch]) observe(mk_ev(cyc, ch, 3'd0));
        for (int i = 0; i < 10; i++)
            if (sw_rise[i]) observe(mk_ev(cyc, 5 + i, 3'd0));
        if (mode_chg) observe(mk_ev(cyc, 15, mode_sel));
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_osc);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        push = '0;
        spdt = '0;

        // 1: reset with toggling inputs, then a button held through release
        for (int i = 0; i < 5; i++) begin
            step(1);
            push = 5'($urandom_range(0, 31));
            spdt = 14'($urandom_range(0, 16383));
            @(negedge clk_osc);
            check("rst_outputs", {30'd0, push_level, push_pulse, sw_level, sw_rise, mode_sel, mode_chg}, 64'd0);
        end
        step(1);
        push = 5'b01000;
        spdt = '0;
        rst  = 1'b0;
        expect_ev(cyc + RST_LAT + LAT, 3, 3'd0);
        step(14);
        check("held_level", {59'd0, push_level}, 64'h08);
        push = '0;
        step(12);
        check("released_level", {59'd0, push_level}, 64'h00);

        // 2: middle button press, release, short glitch, minimal accepted pulse
        push[4] = 1'b1;
        expect_ev(cyc + LAT, 4, 3'd0);
        step(20);
        push[4] = 1'b0;
        step(15);
        push[4] = 1'b1;
        step(D - 1);
        push[4] = 1'b0;
        step(15);
        push[4] = 1'b1;
        expect_ev(cyc + LAT, 4, 3'd0);
        step(D);
        push[4] = 1'b0;
        step(15);

        // 3: up held -> press pulse then auto-repeat until the level drops
        begin
            int e;
            int h;
            h = 55;
            e = cyc;
            push[0] = 1'b1;
            expect_ev(e + LAT, 0, 3'd0);
            // level is still high at edge e + h + 2 + D (release not yet accepted)
            for (int t = e + LAT + RD; t <= e + h + 2 + D; t += RR)
                expect_ev(t, 0, 3'd0);
            step(h);
            push[0] = 1'b0;
            step(25);
        end

        // 4: up and down together -> one press each, no repeats
        push[1:0] = 2'b11;
        expect_ev(cyc + LAT, 0, 3'd0);
        expect_ev(cyc + LAT, 1, 3'd0);
        step(60);
        push[1:0] = 2'b00;
        step(20);

        // 5: mode decode, mode change masking, re-arm after release
        spdt[14] = 1'b1;
        spdt[12] = 1'b1;
        push[2]  = 1'b1;
        expect_ev(cyc + LAT, 15, 3'd1);
        step(20);
        check("mode_time_set", {61'd0, mode_sel}, 64'd1);
        spdt[14] = 1'b0;
        expect_ev(cyc + LAT, 15, 3'd3);
        step(20);
        check("mode_stopwatch", {61'd0, mode_sel}, 64'd3);
        check("left_still_held", {63'd0, push_level[2]}, 64'd1);
        push[2] = 1'b0;
        step(15);
        push[2] = 1'b1;
        expect_ev(cyc + LAT, 2, 3'd0);
        step(15);
        push[2] = 1'b0;
        step(12);
        spdt[12] = 1'b0;
        expect_ev(cyc + LAT, 15, 3'd0);
        step(15);

        // 6: game switch rise, then reset in the middle of a debounce
        spdt[1] = 1'b1;
        expect_ev(cyc + LAT, 5, 3'd0);
        step(12);
        check("sw_level_set", {54'd0, sw_level}, 64'h001);
        spdt[2] = 1'b1;
        step(4);
        rst = 1'b1;
        step(3);
        spdt = '0;
        step(1);
        rst = 1'b0;
        step(20);
        check("sw_level_after_rst", {54'd0, sw_level}, 64'h000);
        check("mode_after_rst", {61'd0, mode_sel}, 64'd0);

        step(5);
        check("pending_events", 64'(exp_q.size()), 64'd0);
        while (exp_q.size() > 0)
            $display("  not seen: event %0h", exp_q.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
